// File: rtl/axis_dsrc_pkg.sv
// Shared constants and types for the axis_dsrc stream source.
// Holds command opcodes, FSM state encoding, LFSR settings and the checksum step.
package axis_dsrc_pkg;

    localparam logic [3:0] OP_START      = 4'd1;
    localparam logic [3:0] OP_CLEAR      = 4'd2;
    localparam logic [3:0] OP_STOP       = 4'd3;
    localparam logic [3:0] OP_SET_PKTLEN = 4'd4;
    localparam logic [3:0] OP_SET_LIMIT  = 4'd5;
    localparam logic [3:0] OP_SET_MODE   = 4'd6;

    localparam logic [31:0] LFSR_POLY      = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED      = 32'h0000_0001;
    localparam logic [15:0] PKTLEN_DEFAULT = 16'd16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Rotate right by one, then add the beat; identical to the sink's algorithm.
    function automatic logic [63:0] csum_step(input logic [63:0] sum, input logic [63:0] data);
        return {sum[0], sum[63:1]} + data;
    endfunction

endpackage

// File: rtl/axis_dsrc_lfsr.sv
// 32-bit Galois LFSR used for the pseudo-random data pattern.
// Exposes both the current value and the value after one more step.
module axis_dsrc_lfsr
    import axis_dsrc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic        clear,
    output logic [31:0] value,
    output logic [31:0] next_value
);

    // Bit 0 of the polynomial is the shifted-out feedback bit itself, not a tap.
    always_comb begin
        next_value = {1'b0, value[31:1]} ^ ({32{value[0]}} & {LFSR_POLY[31:1], 1'b0});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_SEED;
        end else if (clear) begin
            value <= LFSR_SEED;
        end else if (advance) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/axis_dsrc.sv
// Command-driven AXI-stream beat source (counter or LFSR pattern) with
// byte count and rotate-add checksum of every accepted beat.
module axis_dsrc
    import axis_dsrc_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_NUM_BYTES = 4
) (
    input  logic                                  AXIS_ACLK,
    input  logic                                  AXIS_ARESETN,
    output logic                                  M_AXIS_TVALID,
    input  logic                                  M_AXIS_TREADY,
    output logic [8*C_M_AXIS_TDATA_NUM_BYTES-1:0] M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_NUM_BYTES-1:0]   M_AXIS_TSTRB,
    output logic                                  M_AXIS_TLAST,
    input  logic [31:0]                           cmd,
    input  logic                                  new_cmd,
    output logic [31:0]                           stat,
    output logic [31:0]                           sent_bytes,
    output logic [63:0]                           checksum
);

    localparam int unsigned NB  = C_M_AXIS_TDATA_NUM_BYTES;
    localparam int unsigned TW  = 8 * NB;
    localparam int unsigned REP = (TW + 31) / 32;

    state_t         state_q, state_d;
    logic [TW-1:0]  tdata_q;
    logic           tlast_q;
    logic [31:0]    beat_cnt;
    logic [15:0]    pkt_cnt;
    logic [15:0]    pkt_len;
    logic [15:0]    beat_limit;
    logic           mode;
    logic [31:0]    lfsr_value;
    logic [31:0]    lfsr_next;

    logic [3:0]     opcode;
    logic [15:0]    arg;
    logic           do_clear;
    logic           do_start;
    logic           do_stop;
    logic           tvalid;
    logic           accept;
    logic           limit_hit;
    logic [31:0]    beat_nxt;
    logic [15:0]    pkt_nxt;
    logic           unused_cmd_bits;

    assign opcode          = cmd[3:0];
    assign arg             = cmd[31:16];
    assign unused_cmd_bits = ^cmd[15:4];

    assign do_clear = new_cmd && (opcode == OP_CLEAR);
    assign do_start = new_cmd && (opcode == OP_START) && (state_q == IDLE);
    assign do_stop  = new_cmd && (opcode == OP_STOP);

    assign tvalid    = (state_q == RUN) || (state_q == DRAIN);
    assign accept    = tvalid && M_AXIS_TREADY && !do_clear;
    assign limit_hit = (beat_limit != 16'd0) && (beat_cnt == {16'd0, beat_limit} - 32'd1);
    assign beat_nxt  = beat_cnt + 32'd1;
    assign pkt_nxt   = tlast_q ? 16'd0 : pkt_cnt + 16'd1;

    function automatic logic [TW-1:0] pattern(input logic [31:0] beat, input logic [31:0] lv,
                                              input logic lfsr_mode);
        logic [TW+31:0]     ext;
        logic [32*REP-1:0]  rep;
        ext = {{TW{1'b0}}, beat};
        rep = {REP{lv}};
        return lfsr_mode ? rep[TW-1:0] : ext[TW-1:0];
    endfunction

    function automatic logic tlast_fn(input logic [15:0] pkt, input logic [31:0] beat,
                                      input logic [15:0] plen, input logic [15:0] lim);
        return (pkt == plen - 16'd1) || ((lim != 16'd0) && (beat == {16'd0, lim} - 32'd1));
    endfunction

    axis_dsrc_lfsr u_lfsr (
        .clk        (AXIS_ACLK),
        .rst_n      (AXIS_ARESETN),
        .advance    (accept),
        .clear      (do_clear),
        .value      (lfsr_value),
        .next_value (lfsr_next)
    );

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A limit-reaching accept always ends in DONE, even with a STOP in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (do_start) state_d = RUN;
            end
            RUN: begin
                if (accept) begin
                    if (limit_hit)              state_d = DONE;
                    else if (do_stop && tlast_q) state_d = IDLE;
                    else if (do_stop)            state_d = DRAIN;
                end else if (do_stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (accept) begin
                    if (limit_hit)    state_d = DONE;
                    else if (tlast_q) state_d = IDLE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (do_clear) state_d = IDLE;
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
            beat_cnt   <= '0;
            pkt_cnt    <= '0;
            sent_bytes <= '0;
            checksum   <= '0;
            pkt_len    <= PKTLEN_DEFAULT;
            beat_limit <= '0;
            mode       <= 1'b0;
        end else if (do_clear) begin
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
            beat_cnt   <= '0;
            pkt_cnt    <= '0;
            sent_bytes <= '0;
            checksum   <= '0;
        end else begin
            if (new_cmd && state_q == IDLE) begin
                case (opcode)
                    OP_SET_PKTLEN: if (arg != 16'd0) pkt_len <= arg;
                    OP_SET_LIMIT:  beat_limit <= arg;
                    OP_SET_MODE:   mode <= arg[0];
                    default: ;
                endcase
            end
            if (do_start) begin
                tdata_q <= pattern(beat_cnt, lfsr_value, mode);
                tlast_q <= tlast_fn(pkt_cnt, beat_cnt, pkt_len, beat_limit);
            end
            if (accept) begin
                beat_cnt   <= beat_nxt;
                pkt_cnt    <= pkt_nxt;
                sent_bytes <= sent_bytes + 32'(NB);
                checksum   <= csum_step(checksum, 64'(tdata_q));
                tdata_q    <= pattern(beat_nxt, lfsr_next, mode);
                tlast_q    <= tlast_fn(pkt_nxt, beat_nxt, pkt_len, beat_limit);
            end
        end
    end

    assign M_AXIS_TVALID = tvalid;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign M_AXIS_TSTRB  = '1;
    assign stat          = {29'd0, state_q == DRAIN, state_q == DONE, tvalid};

endmodule

// File: tb/tb_axis_dsrc.sv
// Directed self-checking bench for axis_dsrc with N=4 byte beats.
module tb_axis_dsrc;

    logic        clk;
    logic        rst_n;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic [31:0] cmd;
    logic        new_cmd;
    logic [31:0] stat;
    logic [31:0] sent_bytes;
    logic [63:0] checksum;

    int checks = 0;
    int errors = 0;

    axis_dsrc #(.C_M_AXIS_TDATA_NUM_BYTES(4)) dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESETN  (rst_n),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TREADY (tready),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TSTRB  (tstrb),
        .M_AXIS_TLAST  (tlast),
        .cmd           (cmd),
        .new_cmd       (new_cmd),
        .stat          (stat),
        .sent_bytes    (sent_bytes),
        .checksum      (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [15:0] arg);
        cmd     = {arg, 12'h000, op};
        new_cmd = 1'b1;
        tick();
        new_cmd = 1'b0;
        cmd     = '0;
    endtask

    function automatic logic [63:0] sink_step(input logic [63:0] s, input logic [31:0] d);
        return {s[0], s[63:1]} + {32'd0, d};
    endfunction

    logic [63:0] mcks;
    logic [31:0] mbytes;
    int          mbeats;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    initial begin
        rst_n   = 1'b0;
        tready  = 1'b1;
        cmd     = '0;
        new_cmd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_sent", sent_bytes, 0);
        chk("rst_cks", checksum, 0);
        chk("rst_stat", stat, 0);
        chk("rst_tstrb", tstrb, 4'hf);
        rst_n = 1'b1;
        tick();

        // Counter mode, pkt_len 4, limit 4
        send_cmd(4'd4, 16'd4);
        send_cmd(4'd5, 16'd4);
        send_cmd(4'd1, 16'd0);
        chk("t1_stat_run", stat, 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_tvalid", tvalid, 1);
            chk("t1_tdata", tdata, 64'(i));
            chk("t1_tlast", tlast, (i == 3) ? 64'd1 : 64'd0);
            tick();
        end
        chk("t1_tvalid_end", tvalid, 0);
        chk("t1_sent", sent_bytes, 32'd16);
        chk("t1_cks", checksum, 64'h4000000000000004);
        chk("t1_stat", stat, 32'h2);

        // Limit 10 with pkt_len 4 kept across CLEAR
        send_cmd(4'd2, 16'd0);
        chk("clr_stat", stat, 0);
        chk("clr_sent", sent_bytes, 0);
        send_cmd(4'd5, 16'd10);
        send_cmd(4'd1, 16'd0);
        mcks = '0;
        for (int i = 0; i < 10; i++) begin
            chk("t2_tdata", tdata, 64'(i));
            chk("t2_tlast", tlast, (i == 3 || i == 7 || i == 9) ? 64'd1 : 64'd0);
            mcks = sink_step(mcks, 32'(i));
            tick();
        end
        chk("t2_sent", sent_bytes, 32'd40);
        chk("t2_cks", checksum, mcks);
        chk("t2_stat", stat, 32'h2);

        // Random backpressure, limit 12
        send_cmd(4'd2, 16'd0);
        send_cmd(4'd5, 16'd12);
        send_cmd(4'd1, 16'd0);
        mcks = '0;
        mbytes = '0;
        mbeats = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        for (int c = 0; c < 400 && !(tvalid == 1'b0 && stat == 32'h2); c++) begin
            if (prev_stall) begin
                chk("t3_stall_data", tdata, prev_data);
                chk("t3_stall_last", tlast, prev_last);
            end
            tready = 1'($urandom_range(0, 1));
            if (tvalid && tready) begin
                chk("t3_tdata", tdata, 64'(mbeats));
                mcks   = sink_step(mcks, tdata);
                mbytes = mbytes + 32'd4;
                mbeats++;
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
            tick();
        end
        tready = 1'b1;
        chk("t3_done", stat, 32'h2);
        chk("t3_beats", 64'(mbeats), 64'd12);
        chk("t3_sent", sent_bytes, mbytes);
        chk("t3_cks", checksum, mcks);

        // STOP at beat 5, pkt_len 8, unlimited
        send_cmd(4'd2, 16'd0);
        send_cmd(4'd5, 16'd0);
        send_cmd(4'd4, 16'd8);
        send_cmd(4'd1, 16'd0);
        for (int i = 0; i < 8; i++) begin
            chk("t4_tdata", tdata, 64'(i));
            chk("t4_tlast", tlast, (i == 7) ? 64'd1 : 64'd0);
            if (i == 6) chk("t4_stat_drain", stat, 32'h5);
            if (i == 5) begin
                cmd     = {16'd0, 12'h000, 4'd3};
                new_cmd = 1'b1;
            end
            tick();
            new_cmd = 1'b0;
            cmd     = '0;
        end
        chk("t4_tvalid", tvalid, 0);
        chk("t4_stat", stat, 32'h0);
        chk("t4_sent", sent_bytes, 32'd32);

        // LFSR mode, limit 3
        send_cmd(4'd2, 16'd0);
        send_cmd(4'd6, 16'd1);
        send_cmd(4'd5, 16'd3);
        send_cmd(4'd1, 16'd0);
        chk("t5_d0", tdata, 32'h00000001);
        tick();
        chk("t5_d1", tdata, 32'h80200002);
        tick();
        chk("t5_d2", tdata, 32'h40100001);
        chk("t5_last", tlast, 1);
        tick();
        chk("t5_stat", stat, 32'h2);
        chk("t5_sent", sent_bytes, 32'd12);
        chk("t5_cks", checksum, 64'h4000000080200002);

        // CLEAR mid-stream while a beat is being accepted
        send_cmd(4'd2, 16'd0);
        send_cmd(4'd5, 16'd0);
        send_cmd(4'd1, 16'd0);
        chk("t6_d0", tdata, 32'h00000001);
        tick();
        chk("t6_d1", tdata, 32'h80200002);
        tick();
        chk("t6_d2", tdata, 32'h40100001);
        send_cmd(4'd2, 16'd0);
        chk("t6_clr_tvalid", tvalid, 0);
        chk("t6_clr_sent", sent_bytes, 0);
        chk("t6_clr_cks", checksum, 0);
        chk("t6_clr_stat", stat, 0);
        send_cmd(4'd1, 16'd0);
        chk("t6_kept_mode", tdata, 32'h00000001);
        chk("t6_kept_last", tlast, 0);
        tick();
        chk("t6_kept_d1", tdata, 32'h80200002);
        chk("t6_sent_pre", sent_bytes, 32'd4);

        // Asynchronous reset mid-stream, then defaults return
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_tvalid", tvalid, 0);
        chk("t7_rst_tdata", tdata, 0);
        chk("t7_rst_sent", sent_bytes, 0);
        chk("t7_rst_cks", checksum, 0);
        chk("t7_rst_stat", stat, 0);
        tick();
        rst_n = 1'b1;
        tick();
        send_cmd(4'd1, 16'd0);
        for (int i = 0; i < 16; i++) begin
            chk("t7_tdata", tdata, 64'(i));
            chk("t7_tlast", tlast, (i == 15) ? 64'd1 : 64'd0);
            tick();
        end
        chk("t7_stat_run", stat, 32'h1);
        chk("t7_sent", sent_bytes, 32'd64);
        send_cmd(4'd2, 16'd0);
        chk("t7_final_stat", stat, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
